// File: rtl/dmux_stream.sv
// Registered 1-to-NCH stream demultiplexer with a one-entry holding slot per channel.
// Optional per-channel delivery counters are enabled with DMUX_STREAM_STATS_EN.
//
// state | meaning
// ------+------------------------------------------------
// EMPTY | slot holds no beat, out_valid[k]=0
// FULL  | slot holds a beat awaiting out_ready[k]
module dmux_stream #(
  parameter int NCH   = 8,
  parameter int WIDTH = 1,
  parameter int SELW  = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SELW-1:0]      in_sel,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic [NCH*WIDTH-1:0] out_data,
`ifdef DMUX_STREAM_STATS_EN
  output logic [NCH*8-1:0]     stat_count,
`endif
  output logic                 err
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

  slot_state_t state_q [NCH];
  slot_state_t state_d [NCH];
  logic [NCH*WIDTH-1:0] data_q;
  logic [NCH-1:0]       fill;
  logic                 sel_ok;
  logic                 tgt_free;
  logic                 accept;
  logic                 err_d;

  always_comb begin
    sel_ok   = 1'b0;
    tgt_free = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (in_sel == SELW'(k)) begin
        sel_ok   = 1'b1;
        tgt_free = (state_q[k] == EMPTY) || out_ready[k];
      end
    end
    // Out-of-range selects are always accepted so they can be dropped.
    in_ready = !reset && (!sel_ok || tgt_free);
    accept   = in_valid && in_ready;
    err_d    = accept && !sel_ok;

    for (int k = 0; k < NCH; k++) begin
      fill[k]    = accept && (in_sel == SELW'(k));
      state_d[k] = state_q[k];
      case (state_q[k])
        EMPTY: if (fill[k]) state_d[k] = FULL;
        FULL:  if (!fill[k] && out_ready[k]) state_d[k] = EMPTY;
        default: state_d[k] = EMPTY;
      endcase
      out_valid[k] = (state_q[k] == FULL);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NCH; k++) state_q[k] <= EMPTY;
      data_q <= '0;
      err    <= 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        state_q[k] <= state_d[k];
        if (fill[k]) data_q[k*WIDTH +: WIDTH] <= in_data;
      end
      err <= err_d;
    end
  end

  assign out_data = data_q;

`ifdef DMUX_STREAM_STATS_EN
  logic [NCH*8-1:0] stat_q;

  // Counts edges where a held beat is taken; saturates instead of wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_q <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (out_valid[k] && out_ready[k] && (stat_q[k*8 +: 8] != 8'hFF))
          stat_q[k*8 +: 8] <= stat_q[k*8 +: 8] + 8'd1;
      end
    end
  end

  assign stat_count = stat_q;
`endif

endmodule

// File: tb/tb_dmux_stream.sv
// Bench for dmux_stream: table-driven rows with a per-channel data scoreboard,
// plus hand-written reset, invalid-select and (DMUX_STREAM_STATS_EN) counter sequences.
module tb_dmux_stream;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [2:0]  in_sel;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic [63:0] out_data;
  logic        err;

  logic        b_in_valid;
  logic        b_in_ready;
  logic [7:0]  b_in_data;
  logic [2:0]  b_in_sel;
  logic [5:0]  b_out_valid;
  logic [5:0]  b_out_ready;
  logic [47:0] b_out_data;
  logic        b_err;
`ifdef DMUX_STREAM_STATS_EN
  logic [63:0] stat_count;
  logic [47:0] b_stat_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  dmux_stream #(.NCH(8), .WIDTH(8), .SELW(3)) u_dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef DMUX_STREAM_STATS_EN
    .stat_count(stat_count),
`endif
    .err(err)
  );

  dmux_stream #(.NCH(6), .WIDTH(8), .SELW(3)) u_dut6 (
    .clock(clock), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_sel(b_in_sel),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
`ifdef DMUX_STREAM_STATS_EN
    .stat_count(b_stat_count),
`endif
    .err(b_err)
  );

  typedef struct {
    logic       vld;
    logic [2:0] sel;
    logic [7:0] data;
    logic [7:0] ordy;
    logic       exp_rdy;
    logic [7:0] exp_ov;
    logic       exp_err;
  } vec_t;

  vec_t       vecs [$];
  logic [7:0] sbq [8][$];
  logic [7:0] prev_ov;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic vld, input logic [2:0] sel, input logic [7:0] data,
                              input logic [7:0] ordy, input logic rdy, input logic [7:0] ov);
    vec_t v;
    v.vld = vld; v.sel = sel; v.data = data; v.ordy = ordy;
    v.exp_rdy = rdy; v.exp_ov = ov; v.exp_err = 1'b0;
    return v;
  endfunction

  task automatic run_row(input vec_t r, input int idx);
    @(negedge clock);
    in_valid = r.vld; in_sel = r.sel; in_data = r.data; out_ready = r.ordy;
    #1;
    chk($sformatf("in_ready row%0d", idx), {63'd0, in_ready}, {63'd0, r.exp_rdy});
    for (int k = 0; k < 8; k++) begin
      if (prev_ov[k]) begin
        if (sbq[k].size() == 0) begin
          total++; bad++;
          $display("FAIL scoreboard row%0d ch%0d actual=empty required=beat", idx, k);
        end else begin
          chk($sformatf("out_data row%0d ch%0d", idx, k), {56'd0, out_data[k*8 +: 8]}, {56'd0, sbq[k][0]});
          if (r.ordy[k]) void'(sbq[k].pop_front());
        end
      end
    end
    if (r.vld && r.exp_rdy) sbq[r.sel].push_back(r.data);
    @(posedge clock);
    #1;
    chk($sformatf("out_valid row%0d", idx), {56'd0, out_valid}, {56'd0, r.exp_ov});
    chk($sformatf("err row%0d", idx), {63'd0, err}, {63'd0, r.exp_err});
    prev_ov = r.exp_ov;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
    b_in_valid = 1'b0; b_in_sel = '0; b_in_data = '0; b_out_ready = '0;
    prev_ov = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset out_valid", {56'd0, out_valid}, 64'd0);
    chk("reset out_data", out_data, 64'd0);
    chk("reset err", {63'd0, err}, 64'd0);
    chk("reset in_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Sweep every channel with all consumers ready.
    for (int s = 0; s < 8; s++) vecs.push_back(mk(1, 3'(s), 8'h01, 8'hFF, 1, 8'(1 << s)));
    vecs.push_back(mk(0, 0, 8'h00, 8'hFF, 1, 8'h00));
    // Channel 3 stalled; channel 5 still flows.
    vecs.push_back(mk(1, 3, 8'hA5, 8'hF7, 1, 8'h08));
    vecs.push_back(mk(1, 3, 8'h3C, 8'hF7, 0, 8'h08));
    vecs.push_back(mk(1, 3, 8'h3C, 8'hF7, 0, 8'h08));
    vecs.push_back(mk(1, 5, 8'h11, 8'hF7, 1, 8'h28));
    vecs.push_back(mk(0, 5, 8'h00, 8'hF7, 1, 8'h08));
    vecs.push_back(mk(1, 3, 8'h3C, 8'hFF, 1, 8'h08));
    vecs.push_back(mk(0, 0, 8'h00, 8'hFF, 1, 8'h00));
    // Drain and refill channel 2 in one cycle.
    vecs.push_back(mk(1, 2, 8'h01, 8'h00, 1, 8'h04));
    vecs.push_back(mk(1, 2, 8'h02, 8'h04, 1, 8'h04));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 8'h04));
    vecs.push_back(mk(0, 0, 8'h00, 8'h04, 1, 8'h00));
    // Three channels full, then drained together.
    vecs.push_back(mk(1, 0, 8'hC0, 8'h00, 1, 8'h01));
    vecs.push_back(mk(1, 4, 8'hC4, 8'h00, 1, 8'h11));
    vecs.push_back(mk(1, 7, 8'hC7, 8'h00, 1, 8'h91));
    vecs.push_back(mk(1, 0, 8'hEE, 8'h00, 0, 8'h91));
    vecs.push_back(mk(0, 0, 8'h00, 8'h91, 1, 8'h00));
    // Refill 0, 4, 7 ahead of the mid-operation reset.
    vecs.push_back(mk(1, 0, 8'hD0, 8'h00, 1, 8'h01));
    vecs.push_back(mk(1, 4, 8'hD4, 8'h00, 1, 8'h11));
    vecs.push_back(mk(1, 7, 8'hD7, 8'h00, 1, 8'h91));

    for (int i = 0; i < vecs.size(); i++) run_row(vecs[i], i);

    @(negedge clock);
    reset = 1'b1; in_valid = 1'b1; in_sel = 3'd1; in_data = 8'h77; out_ready = 8'h00;
    #1;
    chk("mid reset in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clock);
    #1;
    chk("mid reset out_valid", {56'd0, out_valid}, 64'd0);
    chk("mid reset out_data", out_data, 64'd0);
    chk("mid reset err", {63'd0, err}, 64'd0);
    @(negedge clock);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    chk("post reset in_ready", {63'd0, in_ready}, 64'd1);
    for (int k = 0; k < 8; k++) sbq[k].delete();
    prev_ov = '0;
    @(posedge clock);
    #1;
    chk("post reset out_valid", {56'd0, out_valid}, 64'd0);

    // Out-of-range select on the 6-channel instance.
    @(negedge clock);
    b_in_valid = 1'b1; b_in_sel = 3'd7; b_in_data = 8'h55; b_out_ready = 6'h3F;
    #1;
    chk("sel7 in_ready", {63'd0, b_in_ready}, 64'd1);
    @(posedge clock);
    #1;
    chk("sel7 err", {63'd0, b_err}, 64'd1);
    chk("sel7 out_valid", {58'd0, b_out_valid}, 64'd0);
    @(negedge clock);
    b_in_valid = 1'b0;
    @(posedge clock);
    #1;
    chk("sel7 err one cycle", {63'd0, b_err}, 64'd0);
    @(negedge clock);
    b_in_valid = 1'b1; b_in_sel = 3'd6; b_out_ready = 6'h00;
    @(posedge clock);
    #1;
    chk("sel6 err", {63'd0, b_err}, 64'd1);
    chk("sel6 out_valid", {58'd0, b_out_valid}, 64'd0);
    @(negedge clock);
    b_in_sel = 3'd5; b_in_data = 8'h9A;
    #1;
    chk("sel5 in_ready", {63'd0, b_in_ready}, 64'd1);
    @(posedge clock);
    #1;
    chk("sel5 err", {63'd0, b_err}, 64'd0);
    chk("sel5 out_valid", {58'd0, b_out_valid}, 64'h20);
    chk("sel5 out_data", {56'd0, b_out_data[40 +: 8]}, 64'h9A);
    @(negedge clock);
    b_in_valid = 1'b0;

`ifdef DMUX_STREAM_STATS_EN
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b0; out_ready = 8'h00;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      in_valid = 1'b1; in_sel = 3'd1; in_data = 8'(i); out_ready = 8'h02;
    end
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    for (int k = 0; k < 8; k++)
      chk($sformatf("stat ch%0d", k), {56'd0, stat_count[k*8 +: 8]}, (k == 1) ? 64'd255 : 64'd0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("stat after reset", stat_count, 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
